// File: rtl/pattern_game_core.sv
// pattern_game_core
//   Memory-sequence game engine. After an accepted start it fills a pattern
//   memory from a free-running LFSR. It plays the first round_len steps on
//   the LEDs, then checks the player's button presses against them. Each
//   cleared round lengthens the pattern by one step. The game ends in WIN
//   once MAX_LEN steps are cleared. It ends in LOSE on a wrong press, on
//   simultaneous presses, or on an input timeout.
//
// Ports
//   clk_2      system clock, rising edge
//   rst        synchronous active-high reset
//   start      one-cycle pulse, accepted in IDLE / WIN / LOSE
//   level      difficulty 0..3, latched on an accepted start
//   btn        debounced button levels, 1 = pressed
//   led        LED drive, 1 = lit
//   phase      0 IDLE, 1 GEN, 2 SHOW, 3 GAP, 4 INPUT, 5 WIN, 6 LOSE
//   round_len  pattern length of the current round
//   score      rounds completed in the current game
//   win/lose   high while in WIN / LOSE
module pattern_game_core #(
  parameter int          NUM_CH         = 8,
  parameter int          MAX_LEN        = 16,
  parameter int          SHOW_CYCLES    = 1000,
  parameter int          GAP_CYCLES     = 500,
  parameter int          TIMEOUT_CYCLES = 200000,
  parameter logic [15:0] SEED           = 16'hACE1
) (
  input  logic                     clk_2,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               level,
  input  logic [NUM_CH-1:0]        btn,
  output logic [NUM_CH-1:0]        led,
  output logic [2:0]               phase,
  output logic [$clog2(MAX_LEN):0] round_len,
  output logic [$clog2(MAX_LEN):0] score,
  output logic                     win,
  output logic                     lose
);

  localparam int CW      = $clog2(NUM_CH);
  localparam int AW      = $clog2(MAX_LEN);
  localparam int LW      = AW + 1;
  localparam int GAP_LEN = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int TMAX    = (SHOW_CYCLES > GAP_LEN) ? SHOW_CYCLES : GAP_LEN;
  localparam int TW      = (TMAX < 2) ? 1 : $clog2(TMAX);
  localparam int TOW     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GEN   = 3'd1,
    ST_SHOW  = 3'd2,
    ST_GAP   = 3'd3,
    ST_INPUT = 3'd4,
    ST_WIN   = 3'd5,
    ST_LOSE  = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [1:0]         lv_q, lv_d;
  logic [LW-1:0]      round_len_q, round_len_d;
  logic [LW-1:0]      score_q, score_d;
  logic [LW-1:0]      ptr_q, ptr_d;
  logic [AW-1:0]      gen_cnt_q, gen_cnt_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [TOW-1:0]     tmo_q, tmo_d;
  logic               lead_gap_q, lead_gap_d;
  logic [NUM_CH-1:0]  btn_prev_q, btn_prev_d;

  // Pattern memory: written during GEN, read with one register stage.
  logic [CW-1:0]      mem_q [MAX_LEN];
  logic [CW-1:0]      rd_q;
  logic               mem_we;

  logic [NUM_CH-1:0]  exp_oh;
  logic [NUM_CH-1:0]  rise;
  logic [TW-1:0]      show_last;
  int                 show_len_i;

  // One-hot of the step the player is expected to press / is being shown.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_exp_oh
    assign exp_oh[gi] = (rd_q == CW'(gi));
  end

  assign rise = btn & ~btn_prev_q;

  // Higher difficulty shortens playback; never below one cycle.
  always_comb begin
    show_len_i = SHOW_CYCLES >> lv_q;
    if (show_len_i < 1) show_len_i = 1;
    show_last = TW'(show_len_i - 1);
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
    lv_d        = lv_q;
    round_len_d = round_len_q;
    score_d     = score_q;
    ptr_d       = ptr_q;
    gen_cnt_d   = gen_cnt_q;
    timer_d     = timer_q;
    tmo_d       = tmo_q;
    lead_gap_d  = lead_gap_q;
    btn_prev_d  = btn;
    mem_we      = 1'b0;
    led         = '0;

    case (state_q)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (state_q == ST_WIN)  led = '1;
        if (state_q == ST_LOSE) led = exp_oh;
        if (start) begin
          lv_d = level;
          if (int'(level) + 1 > MAX_LEN) round_len_d = LW'(MAX_LEN);
          else                           round_len_d = LW'(int'(level) + 1);
          score_d    = '0;
          ptr_d      = '0;
          gen_cnt_d  = '0;
          lead_gap_d = 1'b0;
          state_d    = ST_GEN;
        end
      end

      ST_GEN: begin
        mem_we    = 1'b1;
        gen_cnt_d = gen_cnt_q + AW'(1);
        if (gen_cnt_q == AW'(MAX_LEN - 1)) begin
          ptr_d   = '0;
          timer_d = '0;
          state_d = ST_SHOW;
        end
      end

      ST_SHOW: begin
        led     = exp_oh;
        timer_d = timer_q + TW'(1);
        if (timer_q == show_last) begin
          timer_d = '0;
          state_d = ST_GAP;
        end
      end

      ST_GAP: begin
        timer_d = timer_q + TW'(1);
        if (timer_q == TW'(GAP_LEN - 1)) begin
          timer_d = '0;
          if (lead_gap_q) begin
            // Dark interval between the input echo and a new playback.
            lead_gap_d = 1'b0;
            ptr_d      = '0;
            state_d    = ST_SHOW;
          end else if (ptr_q < round_len_q - LW'(1)) begin
            ptr_d   = ptr_q + LW'(1);
            state_d = ST_SHOW;
          end else begin
            ptr_d   = '0;
            tmo_d   = '0;
            state_d = ST_INPUT;
          end
        end
      end

      ST_INPUT: begin
        led = btn;
        if (rise != '0) begin
          tmo_d = '0;
          // Exact match also rejects multiple simultaneous edges.
          if (rise == exp_oh) begin
            if (ptr_q < round_len_q - LW'(1)) begin
              ptr_d = ptr_q + LW'(1);
            end else begin
              score_d = score_q + LW'(1);
              if (round_len_q == LW'(MAX_LEN)) begin
                state_d = ST_WIN;
              end else begin
                round_len_d = round_len_q + LW'(1);
                ptr_d       = '0;
                timer_d     = '0;
                lead_gap_d  = 1'b1;
                state_d     = ST_GAP;
              end
            end
          end else begin
            // ptr is held so LOSE shows the button that was expected.
            state_d = ST_LOSE;
          end
        end else if (TIMEOUT_CYCLES != 0) begin
          if (tmo_q == TOW'(TIMEOUT_CYCLES - 1)) state_d = ST_LOSE;
          else                                   tmo_d   = tmo_q + TOW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lfsr_q      <= SEED;
      lv_q        <= '0;
      round_len_q <= '0;
      score_q     <= '0;
      ptr_q       <= '0;
      gen_cnt_q   <= '0;
      timer_q     <= '0;
      tmo_q       <= '0;
      lead_gap_q  <= 1'b0;
      btn_prev_q  <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      lv_q        <= lv_d;
      round_len_q <= round_len_d;
      score_q     <= score_d;
      ptr_q       <= ptr_d;
      gen_cnt_q   <= gen_cnt_d;
      timer_q     <= timer_d;
      tmo_q       <= tmo_d;
      lead_gap_q  <= lead_gap_d;
      btn_prev_q  <= btn_prev_d;
    end
  end

  // Reading at ptr_d keeps rd_q aligned with ptr_q in every state.
  always_ff @(posedge clk_2) begin
    if (mem_we) mem_q[gen_cnt_q] <= lfsr_q[CW-1:0];
    rd_q <= mem_q[ptr_d[AW-1:0]];
  end

  assign phase     = state_q;
  assign round_len = round_len_q;
  assign score     = score_q;
  assign win       = (state_q == ST_WIN);
  assign lose      = (state_q == ST_LOSE);

endmodule

// File: tb/tb_pattern_game_core.sv
module tb_pattern_game_core;

  localparam int          NCH  = 4;
  localparam int          ML   = 4;
  localparam int          SC   = 8;
  localparam int          GC   = 4;
  localparam int          TO   = 50;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk_2 = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic [1:0] level = 2'd0;
  logic [3:0] btn   = 4'd0;
  logic [3:0] led;
  logic [2:0] phase;
  logic [2:0] round_len;
  logic [2:0] score;
  logic       win;
  logic       lose;

  int tests = 0;
  int fails = 0;

  logic [15:0] m_lfsr;
  logic [1:0]  exp_pat [ML];

  typedef struct {
    string      nm;
    logic [2:0] ph;
    logic [2:0] sc;
    logic [2:0] rl;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0] lv;
    int         rl;
    int         sl;
    logic [2:0] ph_after;
  } vec_t;
  vec_t vecs [4];

  pattern_game_core #(
    .NUM_CH(NCH), .MAX_LEN(ML), .SHOW_CYCLES(SC), .GAP_CYCLES(GC),
    .TIMEOUT_CYCLES(TO), .SEED(SEED)
  ) dut (
    .clk_2(clk_2), .rst(rst), .start(start), .level(level), .btn(btn),
    .led(led), .phase(phase), .round_len(round_len), .score(score),
    .win(win), .lose(lose)
  );

  always #5 clk_2 = ~clk_2;

  // Reference 16-bit Galois LFSR, taps 0xB400, advancing every unreset clock.
  always @(posedge clk_2) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  end

  function automatic logic [3:0] oh(input logic [1:0] i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic sb_push(input string nm, input logic [2:0] ph, input logic [2:0] sc,
                         input logic [2:0] rl);
    exp_t e;
    e.nm = nm; e.ph = ph; e.sc = sc; e.rl = rl;
    sb.push_back(e);
  endtask

  task automatic sb_pop();
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL sb_empty: got no expected entry, required one");
    end else begin
      e = sb.pop_front();
      chk({e.nm, "_phase"}, phase, e.ph);
      chk({e.nm, "_score"}, score, e.sc);
      chk({e.nm, "_round_len"}, round_len, e.rl);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_phase", phase, 0);
    chk("rst_led", led, 0);
    chk("rst_score", score, 0);
    chk("rst_round_len", round_len, 0);
    chk("rst_winlose", {win, lose}, 0);
  endtask

  // Start a game and capture the expected pattern from the reference LFSR.
  task automatic do_start(input logic [1:0] lv, input int rl);
    start = 1'b1;
    level = lv;
    sb_push("start", 3'd1, 3'd0, 3'(rl));
    tick();
    start = 1'b0;
    $display("[TB] start level=%0d -> phase=%0d round_len=%0d", lv, phase, round_len);
    sb_pop();
    for (int i = 0; i < ML; i++) begin
      chk("gen_phase", phase, 1);
      chk("gen_led", led, 0);
      chk("gen_winlose", {win, lose}, 0);
      exp_pat[i] = m_lfsr[1:0];
      tick();
    end
  endtask

  task automatic play_show(input int rl, input int sl);
    for (int s = 0; s < rl; s++) begin
      for (int c = 0; c < sl; c++) begin
        chk("show_phase", phase, 2);
        chk("show_led", led, oh(exp_pat[s]));
        tick();
      end
      for (int c = 0; c < GC; c++) begin
        chk("gap_phase", phase, 3);
        chk("gap_led", led, 0);
        tick();
      end
    end
    chk("input_phase", phase, 4);
  endtask

  task automatic press(input logic [3:0] mask, input logic [2:0] ph, input logic [2:0] sc,
                       input logic [2:0] rl);
    btn = mask;
    #1;
    chk("echo_led", led, mask);
    sb_push("press", ph, sc, rl);
    @(posedge clk_2);
    #1;
    btn = '0;
    $display("[TB] press btn=%b -> phase=%0d score=%0d round_len=%0d", mask, phase, score, round_len);
    sb_pop();
  endtask

  task automatic replay(input int rl, input logic [2:0] fin_ph, input int sc0);
    for (int i = 0; i < rl; i++) begin
      if (i < rl - 1) begin
        press(oh(exp_pat[i]), 3'd4, 3'(sc0), 3'(rl));
        chk("between_phase", phase, 4);
        tick();
      end else begin
        press(oh(exp_pat[i]), fin_ph, 3'(sc0 + 1), (fin_ph == 3'd3) ? 3'(rl + 1) : 3'(rl));
        if (fin_ph == 3'd3) begin
          for (int c = 0; c < GC; c++) begin
            chk("lead_gap_phase", phase, 3);
            chk("lead_gap_led", led, 0);
            tick();
          end
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{lv: 2'd0, rl: 1, sl: 8, ph_after: 3'd3};
    vecs[1] = '{lv: 2'd1, rl: 2, sl: 4, ph_after: 3'd3};
    vecs[2] = '{lv: 2'd2, rl: 3, sl: 2, ph_after: 3'd3};
    vecs[3] = '{lv: 2'd3, rl: 4, sl: 1, ph_after: 3'd5};

    tick();
    tick();
    do_reset();

    // Full game at level 0: rounds of length 1..4, then WIN.
    do_start(2'd0, 1);
    for (int r = 1; r <= ML; r++) begin
      play_show(r, SC);
      replay(r, (r < ML) ? 3'd3 : 3'd5, r - 1);
    end
    chk("win_flag", win, 1);
    chk("win_led", led, 4'b1111);
    tick();
    tick();
    chk("win_hold_phase", phase, 5);
    chk("win_hold_score", score, 4);

    // One round at each level, from reset.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      do_start(vecs[v].lv, vecs[v].rl);
      play_show(vecs[v].rl, vecs[v].sl);
      replay(vecs[v].rl, vecs[v].ph_after, 0);
      if (vecs[v].ph_after == 3'd5) begin
        chk("lvl_win", win, 1);
        chk("lvl_win_score", score, 1);
      end else begin
        chk("lvl_next_show_phase", phase, 2);
        chk("lvl_next_show_led", led, oh(exp_pat[0]));
      end
    end

    // Wrong button in round 1.
    do_reset();
    do_start(2'd0, 1);
    play_show(1, SC);
    press(oh(exp_pat[0] + 2'd1), 3'd6, 3'd0, 3'd1);
    chk("wrong_lose", lose, 1);
    chk("wrong_led", led, oh(exp_pat[0]));

    // Restart from LOSE, then a pure timeout.
    do_start(2'd0, 1);
    play_show(1, SC);
    for (int k = 0; k < TO - 1; k++) begin
      chk("tmo_wait_phase", phase, 4);
      tick();
    end
    chk("tmo_last_phase", phase, 4);
    tick();
    chk("tmo_lose_phase", phase, 6);
    chk("tmo_lose_led", led, oh(exp_pat[0]));

    // Correct press on the 49th idle cycle restarts the timeout count.
    do_start(2'd1, 2);
    play_show(2, SC >> 1);
    for (int k = 0; k < TO - 2; k++) begin
      chk("tmo2_wait_phase", phase, 4);
      tick();
    end
    press(oh(exp_pat[0]), 3'd4, 3'd0, 3'd2);
    for (int k = 0; k < TO - 1; k++) begin
      chk("tmo2_rewait_phase", phase, 4);
      tick();
    end
    chk("tmo2_last_phase", phase, 4);
    tick();
    chk("tmo2_lose_phase", phase, 6);
    chk("tmo2_lose_led", led, oh(exp_pat[1]));

    // Two buttons rising together.
    do_start(2'd0, 1);
    play_show(1, SC);
    press(oh(exp_pat[0]) | oh(exp_pat[0] + 2'd1), 3'd6, 3'd0, 3'd1);
    chk("dual_lose", lose, 1);

    // Start ignored during SHOW, then reset mid-SHOW in round 2.
    do_start(2'd0, 1);
    play_show(1, SC);
    replay(1, 3'd3, 0);
    tick();
    tick();
    start = 1'b1;
    level = 2'd3;
    tick();
    start = 1'b0;
    $display("[TB] start during SHOW -> phase=%0d round_len=%0d", phase, round_len);
    chk("ign_start_phase", phase, 2);
    chk("ign_start_round_len", round_len, 2);
    chk("ign_start_score", score, 1);
    chk("ign_start_led", led, oh(exp_pat[0]));
    do_reset();

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
